// File: rtl/shift_link_rx_pkg.sv
// shift_link_pkg: framing constants and FSM states shared by both ends of the shift link.
package shift_link_pkg;
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;
endpackage

// File: rtl/shift_link_rx_if.sv
// shift_link_rx_if: serial input side and parallel result side of the link receiver.
interface shift_link_rx_if #(parameter int WIDTH = 4, parameter int CNT_W = 8);
  logic             enb;
  logic             dir;
  logic             s_in;
  logic [WIDTH-1:0] q;
  logic             valid;
  logic             frame_err;
  logic             busy;
  logic [CNT_W-1:0] words;
  modport master(output enb, dir, s_in, input q, valid, frame_err, busy, words);
  modport slave(input enb, dir, s_in, output q, valid, frame_err, busy, words);
endinterface

// File: rtl/shift_link_rx_deser.sv
// shift_link_deser: WIDTH-bit bidirectional deserializer; dir=right feeds the MSB so the first bit lands in bit 0.
module shift_link_deser
  import shift_link_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enb,
  input  logic             i_dir,
  input  logic             i_d,
  output logic [WIDTH-1:0] o_q
);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_q <= '0;
    else if (i_enb) o_q <= (i_dir == DIR_RIGHT) ? {i_d, o_q[WIDTH-1:1]} : {o_q[WIDTH-2:0], i_d};
endmodule

// File: rtl/shift_link_rx.sv
// shift_link_rx: framed serial receiver (start 1, WIDTH data bits, stop 0) with strobes and a good-word count.
module shift_link_rx
  import shift_link_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic            i_clk,
  input logic            i_rst_n,
  shift_link_rx_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           r_state;
  logic             r_dir;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic             r_valid;
  logic             r_err;
  logic [CNT_W-1:0] r_words;
  logic [WIDTH-1:0] w_deser;
  logic             w_shift;
  assign w_shift = bus.enb && (r_state == DATA);
  shift_link_deser #(.WIDTH(WIDTH)) u_deser (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_enb  (w_shift),
    .i_dir  (r_dir),
    .i_d    (bus.s_in),
    .o_q    (w_deser)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_dir   <= DIR_LEFT;
      r_cnt   <= '0;
      r_q     <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_words <= '0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (bus.enb)
        case (r_state)
          IDLE: if (bus.s_in == START_BIT) begin
            r_state <= DATA;
            r_dir   <= bus.dir;
            r_cnt   <= '0;
          end
          DATA: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH - 1)) r_state <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
            if (bus.s_in == STOP_BIT) begin
              r_q     <= w_deser;
              r_valid <= 1'b1;
              r_words <= r_words + 1'b1;
            end else r_err <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
    end
  assign bus.q         = r_q;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_err;
  assign bus.busy      = (r_state != IDLE);
  assign bus.words     = r_words;
endmodule
